ddr4_cal_sequencer: RTL and testbench

//  Sequences bring-up of the DDR4 EMIF (bank B) after FPGA init: pulses the EMIF local reset request,

---
 rtl/ddr4_cal_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_ddr4_cal_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr4_cal_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ddr4_cal_sequencer                                         |
// | Description : Bring-up sequencer for the DDR4 EMIF. It pulses the EMIF   |
// |               local reset request, then waits for reset-done and the     |
// |               calibration result. Failed attempts are retried a bounded  |
// |               number of times. It publishes mem_ready / mem_error and    |
// |               board LED status.                                          |
// | Ports       : clk_i, reset_i       clock, synchronous active-high reset  |
// |               enable_i             1 = bring memory up, 0 = go idle      |
// |               local_reset_req_o    EMIF local reset request              |
// |               local_reset_done_i   EMIF reset done (async)               |
// |               cal_success_i        EMIF calibration success (async)      |
// |               cal_fail_i           EMIF calibration fail (async)         |
// |               mem_ready_o          memory calibrated and usable          |
// |               mem_error_o          all attempts exhausted                |
// |               retry_count_o        failed attempts so far                |
// |               state_dbg_o          FSM state encoding                    |
// |               led_o                {heartbeat, busy, error, ready}       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module ddr4_cal_sequencer #(
  parameter int RESET_PULSE_CYCLES = 16,
  parameter int CAL_TIMEOUT_CYCLES = 50000000,
  parameter int MAX_RETRIES        = 3,
  parameter int SYNC_STAGES        = 2,
  parameter int HEARTBEAT_LOG2     = 24,
  localparam int RC_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            enable_i,
  output logic            local_reset_req_o,
  input  logic            local_reset_done_i,
  input  logic            cal_success_i,
  input  logic            cal_fail_i,
  output logic            mem_ready_o,
  output logic            mem_error_o,
  output logic [RC_W-1:0] retry_count_o,
  output logic [2:0]      state_dbg_o,
  output logic [3:0]      led_o
);

  // The single timer serves both the reset pulse and the wait timeouts, so
  // it is sized for whichever terminal count is larger.
  localparam int TMR_LIMIT = (CAL_TIMEOUT_CYCLES > RESET_PULSE_CYCLES) ?
                             CAL_TIMEOUT_CYCLES : RESET_PULSE_CYCLES;
  localparam int TIMER_W   = $clog2(TMR_LIMIT + 1);

  localparam logic [TIMER_W-1:0] PULSE_LAST   = TIMER_W'(RESET_PULSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(CAL_TIMEOUT_CYCLES - 1);
  localparam logic [RC_W-1:0]    RETRY_MAX    = RC_W'(MAX_RETRIES);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT_RST = 3'd2;
  localparam logic [2:0] ST_WAIT_CAL = 3'd3;
  localparam logic [2:0] ST_READY    = 3'd4;
  localparam logic [2:0] ST_FAILED   = 3'd5;

  localparam int NSYNC = 3;

  // --------------------------------------------------------------------------
  // Input synchronisers: bit 0 reset_done, bit 1 cal_success, bit 2 cal_fail
  // --------------------------------------------------------------------------
  logic [NSYNC-1:0] async_in;
  logic [NSYNC-1:0] synced;

  assign async_in = {cal_fail_i, cal_success_i, local_reset_done_i};

  for (genvar gi = 0; gi < NSYNC; gi++) begin : g_sync
    logic [SYNC_STAGES-1:0] stage_q;

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        stage_q <= '0;
      end else begin
        stage_q <= {stage_q[SYNC_STAGES-2:0], async_in[gi]};
      end
    end

    assign synced[gi] = stage_q[SYNC_STAGES-1];
  end

  logic local_reset_done_s;
  logic cal_success_s;
  logic cal_fail_s;

  assign local_reset_done_s = synced[0];
  assign cal_success_s      = synced[1];
  assign cal_fail_s         = synced[2];

  // --------------------------------------------------------------------------
  // State, timer, retry counter
  // --------------------------------------------------------------------------
  logic [2:0]          state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [RC_W-1:0]     retry_q, retry_d;
  logic                attempt_fail;

  always_comb begin
    state_d      = state_q;
    attempt_fail = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          state_d = ST_RST_REQ;
        end
      end
      ST_RST_REQ: begin
        if (timer_q == PULSE_LAST) begin
          state_d = ST_WAIT_RST;
        end
      end
      ST_WAIT_RST: begin
        if (local_reset_done_s) begin
          state_d = ST_WAIT_CAL;
        end else if (timer_q == TIMEOUT_LAST) begin
          attempt_fail = 1'b1;
        end
      end
      ST_WAIT_CAL: begin
        // A simultaneous fail and success is treated as a fail.
        if (cal_fail_s || (timer_q == TIMEOUT_LAST)) begin
          attempt_fail = 1'b1;
        end else if (cal_success_s) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        // Losing reset-done or a late fail means calibration is gone.
        if (cal_fail_s || !local_reset_done_s) begin
          attempt_fail = 1'b1;
        end
      end
      ST_FAILED: begin
        state_d = ST_FAILED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    retry_d = retry_q;
    if (attempt_fail) begin
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + RC_W'(1);
        state_d = ST_RST_REQ;
      end else begin
        state_d = ST_FAILED;
      end
    end

    // Disable overrides everything and may truncate a reset pulse.
    if (!enable_i) begin
      state_d = ST_IDLE;
    end

    if (state_d == ST_IDLE) begin
      retry_d = '0;
    end
  end

  // Timer restarts from zero on every state entry and only runs while an
  // attempt is in progress.
  always_comb begin
    timer_d = '0;
    if ((state_d == state_q) &&
        ((state_q == ST_RST_REQ) || (state_q == ST_WAIT_RST) ||
         (state_q == ST_WAIT_CAL))) begin
      timer_d = timer_q + TIMER_W'(1);
    end
  end

  // Status outputs are registered from the next state so they change on the
  // same edge as the state register and carry no combinational input path.
  logic req_q, ready_q, error_q, busy_q;
  logic [HEARTBEAT_LOG2-1:0] hb_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      retry_q <= '0;
      req_q   <= 1'b0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
      hb_q    <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      req_q   <= (state_d == ST_RST_REQ);
      ready_q <= (state_d == ST_READY);
      error_q <= (state_d == ST_FAILED);
      busy_q  <= (state_d == ST_RST_REQ) || (state_d == ST_WAIT_RST) ||
                 (state_d == ST_WAIT_CAL);
      hb_q    <= hb_q + HEARTBEAT_LOG2'(1);
    end
  end

  assign local_reset_req_o = req_q;
  assign mem_ready_o       = ready_q;
  assign mem_error_o       = error_q;
  assign retry_count_o     = retry_q;
  assign state_dbg_o       = state_q;
  assign led_o             = {hb_q[HEARTBEAT_LOG2-1], busy_q, error_q, ready_q};

endmodule
`default_nettype wire

// File: tb/tb_ddr4_cal_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ddr4_cal_sequencer                                      |
// | Description : Self-checking bench for ddr4_cal_sequencer with an EMIF    |
// |               responder and an attempt-outcome reference model.          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_ddr4_cal_sequencer;

  localparam int PULSE = 4;
  localparam int TMO   = 100;
  localparam int MAXR  = 2;
  localparam int SYNC  = 2;
  localparam int HBL   = 5;

  localparam int K_SUCC   = 0;
  localparam int K_FAIL   = 1;
  localparam int K_BOTH   = 2;
  localparam int K_NODONE = 3;
  localparam int K_NOCAL  = 4;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       enable = 1'b0;
  logic       done   = 1'b0;
  logic       succ   = 1'b0;
  logic       fail   = 1'b0;
  logic       req, ready, err;
  logic [1:0] retry;
  logic [2:0] st;
  logic [3:0] led;

  int n_cmp  = 0;
  int n_err  = 0;
  int hb_cnt = 0;

  always #5 clk = ~clk;

  ddr4_cal_sequencer #(
    .RESET_PULSE_CYCLES (PULSE),
    .CAL_TIMEOUT_CYCLES (TMO),
    .MAX_RETRIES        (MAXR),
    .SYNC_STAGES        (SYNC),
    .HEARTBEAT_LOG2     (HBL)
  ) u_dut (
    .clk_i              (clk),
    .reset_i            (reset),
    .enable_i           (enable),
    .local_reset_req_o  (req),
    .local_reset_done_i (done),
    .cal_success_i      (succ),
    .cal_fail_i         (fail),
    .mem_ready_o        (ready),
    .mem_error_o        (err),
    .retry_count_o      (retry),
    .state_dbg_o        (st),
    .led_o              (led)
  );

  // Heartbeat reference: edges since the last edge that sampled reset high.
  task automatic tick();
    @(posedge clk);
    #1;
    if (reset) hb_cnt = 0;
    else hb_cnt++;
  endtask

  function automatic logic hb_exp();
    return hb_cnt[HBL-1];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_out(input int sel);
    case (sel)
      0:       return req;
      1:       return ready;
      2:       return err;
      default: return (st == 3'd3);
    endcase
  endfunction

  task automatic wait_hi(input string tag, input int sel, input int bound, output int n);
    n = 0;
    while (get_out(sel) !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, get_out(sel)}, 1);
  endtask

  // Entered with the first cycle of a reset pulse observed.
  task automatic do_attempt(input int kind, input int a, input bit last,
                            input int dd, input int cd);
    int w;
    int n;
    chk("pulse_state", st, 1);
    chk("pulse_retry", retry, a);
    chk("pulse_busy_led", led[2], 1);
    w = 1;
    while (req === 1'b1 && w < 20) begin
      tick();
      if (req === 1'b1) w++;
    end
    chk("pulse_width", w, PULSE);
    chk("wait_rst_state", st, 2);
    if (kind != K_NODONE) begin
      repeat (dd) tick();
      done = 1'b1;
      repeat (cd) tick();
      case (kind)
        K_SUCC:  succ = 1'b1;
        K_FAIL:  fail = 1'b1;
        K_BOTH:  begin succ = 1'b1; fail = 1'b1; end
        default: ;
      endcase
    end
    if (kind == K_SUCC) begin
      repeat (SYNC) tick();
      chk("ready_latency_early", ready, 0);
      tick();
      chk("ready_latency", ready, 1);
      chk("ready_err", err, 0);
      chk("ready_retry", retry, a);
      chk("ready_state", st, 4);
      chk("ready_led", led[2:0], 3'b001);
      chk("ready_hb", led[3], hb_exp());
    end else begin
      n = 0;
      while (req !== 1'b1 && err !== 1'b1 && n < 300) begin
        tick();
        n++;
      end
      if (kind == K_NODONE) chk("wait_rst_timeout", n, TMO);
      if (kind == K_FAIL || kind == K_BOTH) chk("fail_latency", n, SYNC + 1);
      if (last) begin
        chk("final_err", err, 1);
        chk("final_ready", ready, 0);
        chk("final_retry", retry, MAXR);
        chk("final_state", st, 5);
        chk("final_led", led[2:0], 3'b010);
        chk("final_hb", led[3], hb_exp());
      end else begin
        chk("retry_req", req, 1);
        chk("retry_err", err, 0);
      end
      done = 1'b0;
      succ = 1'b0;
      fail = 1'b0;
    end
  endtask

  task automatic run_scenario(input int k0, input int k1, input int k2, input bit rnd);
    int kinds[3];
    int first_succ;
    int n;
    int extra;
    kinds = '{k0, k1, k2};
    first_succ = -1;
    for (int i = 0; i < 3; i++) begin
      if (first_succ < 0 && kinds[i] == K_SUCC) first_succ = i;
    end
    enable = 1'b1;
    wait_hi("start_req", 0, 10, n);
    chk("start_latency", n, 1);
    for (int a = 0; a <= MAXR; a++) begin
      do_attempt(kinds[a], a, (a == MAXR),
                 rnd ? int'($urandom_range(1, 60)) : 10,
                 rnd ? int'($urandom_range(1, 60)) : 20);
      if (kinds[a] == K_SUCC) break;
    end
    chk("model_ready", ready, (first_succ >= 0));
    chk("model_error", err, (first_succ < 0));
    chk("model_retry", retry, (first_succ >= 0) ? first_succ : MAXR);
    extra = 0;
    repeat (30) begin
      tick();
      if (req === 1'b1) extra++;
    end
    chk("no_extra_pulse", extra, 0);
  endtask

  task automatic disable_check();
    enable = 1'b0;
    done   = 1'b0;
    succ   = 1'b0;
    fail   = 1'b0;
    tick();
    chk("idle_state", st, 0);
    chk("idle_req", req, 0);
    chk("idle_ready", ready, 0);
    chk("idle_err", err, 0);
    chk("idle_retry", retry, 0);
    chk("idle_led", led[2:0], 3'b000);
    chk("idle_hb", led[3], hb_exp());
    repeat (3) tick();
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) tick();
    chk("rst_state", st, 0);
    chk("rst_req", req, 0);
    chk("rst_ready", ready, 0);
    chk("rst_err", err, 0);
    chk("rst_retry", retry, 0);
    chk("rst_led", led, 4'b0000);
    reset = 1'b0;
    repeat (20) tick();
    chk("hb_toggle", led[3], hb_exp());
    chk("idle_no_req", req, 0);

    // Happy path followed by loss of calibration while READY
    run_scenario(K_SUCC, K_SUCC, K_SUCC, 1'b0);
    done = 1'b0;
    succ = 1'b0;
    tick();
    tick();
    chk("lost_ready_hold", ready, 1);
    tick();
    chk("lost_ready_drop", ready, 0);
    chk("lost_req", req, 1);
    chk("lost_retry", retry, 1);
    do_attempt(K_SUCC, 1, 1'b0, 10, 20);
    disable_check();

    // Cal fail twice then success
    run_scenario(K_FAIL, K_FAIL, K_SUCC, 1'b0);
    disable_check();

    // reset_done never rises
    run_scenario(K_NODONE, K_NODONE, K_NODONE, 1'b0);
    chk("failed_hold_state", st, 5);
    disable_check();

    // Simultaneous success and fail counts as fail
    run_scenario(K_BOTH, K_SUCC, K_SUCC, 1'b0);
    disable_check();

    // enable dropped in the second pulse cycle
    enable = 1'b1;
    wait_hi("trunc_start", 0, 10, n);
    tick();
    chk("trunc_pulse_c2", req, 1);
    enable = 1'b0;
    tick();
    chk("trunc_req", req, 0);
    chk("trunc_state", st, 0);
    chk("trunc_led", led[2:0], 3'b000);
    repeat (3) tick();
    run_scenario(K_SUCC, K_SUCC, K_SUCC, 1'b1);
    disable_check();

    // Reset asserted while waiting for calibration
    enable = 1'b1;
    wait_hi("wc_start", 0, 10, n);
    repeat (PULSE) tick();
    done = 1'b1;
    wait_hi("wc_reach", 3, 10, n);
    reset = 1'b1;
    tick();
    chk("wc_rst_state", st, 0);
    chk("wc_rst_req", req, 0);
    chk("wc_rst_retry", retry, 0);
    chk("wc_rst_led", led, 4'b0000);
    enable = 1'b0;
    done   = 1'b0;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("wc_post_state", st, 0);

    // Randomized attempt sequences
    for (int s = 0; s < 8; s++) begin
      run_scenario(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                   int'($urandom_range(0, 4)), 1'b1);
      disable_check();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
